// File: rtl/sram_col_access_ctrl_if.sv
// Request/response handshake bundle for the SRAM column access sequencer.
// master: requester side (drives req_*); slave: sequencer side (drives ready/rsp_*).
interface sram_col_access_ctrl_if #(
    parameter int WORD = 32,
    parameter int AW   = 9
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [AW-1:0]   req_addr;
    logic [WORD-1:0] req_wdata;
    logic            rsp_valid;
    logic [WORD-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_col_access_ctrl.sv
// Access sequencer for a ROWSxCOLS SRAM macro with COLS/WORD:1 column muxing.
// Ports: clk, rst (sync, active-high); bus (req/rsp handshake, slave modport);
//   precharge_en, wl_en (one-hot), col_sel (one-hot mux S), write_en, sense_en,
//   bl_wdata (to write drivers), bl_rdata (from sense amps).
// Optional: SRAM_CTRL_BREAK_BEFORE_MAKE_EN adds SETUP/HOLD states so the mux
//   direction never changes while a column select is on.
module sram_col_access_ctrl #(
    parameter int ROWS    = 128,
    parameter int COLS    = 128,
    parameter int WORD    = 32,
    parameter int PRE_CYC = 2,
    parameter int WL_CYC  = 3,
    localparam int MUX    = COLS / WORD,
    localparam int RW     = $clog2(ROWS),
    localparam int CW     = $clog2(MUX)
) (
    input  logic              clk,
    input  logic              rst,
    sram_col_access_ctrl_if.slave bus,
    output logic              precharge_en,
    output logic [ROWS-1:0]   wl_en,
    output logic [MUX-1:0]    col_sel,
    output logic              write_en,
    output logic              sense_en,
    output logic [WORD-1:0]   bl_wdata,
    input  logic [WORD-1:0]   bl_rdata
);
    localparam int CMAX  = (PRE_CYC > WL_CYC) ? PRE_CYC : WL_CYC;
    localparam int CNT_W = (CMAX < 2) ? 1 : $clog2(CMAX);

    typedef enum logic [2:0] {
        IDLE, PRECH, SETUP, ACCESS, HOLD, DONE
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    logic            r_we, w_we_nxt;
    logic [RW-1:0]   r_row, w_row_nxt;
    logic [CW-1:0]   r_col, w_col_nxt;
    logic [WORD-1:0] r_wdata, w_wdata_nxt;

    logic            r_ready, w_ready_nxt;
    logic            r_rsp, w_rsp_nxt;
    logic [WORD-1:0] r_rdata;
    logic            r_pre, w_pre_nxt;
    logic [ROWS-1:0] r_wl, w_wl_nxt;
    logic [MUX-1:0]  r_csel, w_csel_nxt;
    logic            r_wen, w_wen_nxt;
    logic            r_sense, w_sense_nxt;
    logic            w_accept;
    logic            w_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = PRECH;
                    w_cnt_nxt   = '0;
                end
            end
            PRECH: begin
                if (r_cnt == CNT_W'(PRE_CYC - 1)) begin
`ifdef SRAM_CTRL_BREAK_BEFORE_MAKE_EN
                    w_state_nxt = SETUP;
`else
                    w_state_nxt = ACCESS;
`endif
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            SETUP: begin
                w_state_nxt = ACCESS;
                w_cnt_nxt   = '0;
            end
            ACCESS: begin
                if (r_cnt == CNT_W'(WL_CYC - 1)) begin
`ifdef SRAM_CTRL_BREAK_BEFORE_MAKE_EN
                    w_state_nxt = HOLD;
`else
                    w_state_nxt = DONE;
`endif
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            HOLD:    w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are registered, so decode them from the next state and the
    // next latched request; they then line up with the state they describe.
    always_comb begin
        w_we_nxt    = w_accept ? bus.req_we : r_we;
        w_row_nxt   = w_accept ? bus.req_addr[RW+CW-1:CW] : r_row;
        w_col_nxt   = w_accept ? bus.req_addr[CW-1:0] : r_col;
        w_wdata_nxt = w_accept ? bus.req_wdata : r_wdata;
        w_acc       = (w_state_nxt == ACCESS);
        w_pre_nxt   = (w_state_nxt == PRECH);
        w_wl_nxt    = w_acc ? (ROWS'(1) << w_row_nxt) : '0;
        w_csel_nxt  = w_acc ? (MUX'(1) << w_col_nxt) : '0;
        // SETUP/HOLD only occur with break-before-make; they carry write_en
        // while the selects are off.
        w_wen_nxt   = w_we_nxt && (w_acc ||
                                   (w_state_nxt == SETUP) ||
                                   (w_state_nxt == HOLD));
        w_sense_nxt = w_acc && !w_we_nxt &&
                      (w_cnt_nxt == CNT_W'(WL_CYC - 1));
        w_rsp_nxt   = (w_state_nxt == DONE);
        w_ready_nxt = (w_state_nxt == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_row   <= '0;
            r_col   <= '0;
            r_wdata <= '0;
            r_ready <= 1'b1;
            r_rsp   <= 1'b0;
            r_rdata <= '0;
            r_pre   <= 1'b0;
            r_wl    <= '0;
            r_csel  <= '0;
            r_wen   <= 1'b0;
            r_sense <= 1'b0;
        end else begin
            r_we    <= w_we_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
            r_wdata <= w_wdata_nxt;
            r_ready <= w_ready_nxt;
            r_rsp   <= w_rsp_nxt;
            r_pre   <= w_pre_nxt;
            r_wl    <= w_wl_nxt;
            r_csel  <= w_csel_nxt;
            r_wen   <= w_wen_nxt;
            r_sense <= w_sense_nxt;
            // Capture on the edge that ends the strobed cycle.
            if (r_sense) begin
                r_rdata <= bl_rdata;
            end
        end
    end

    assign bus.req_ready = r_ready;
    assign bus.rsp_valid = r_rsp;
    assign bus.rsp_rdata = r_rdata;
    assign precharge_en  = r_pre;
    assign wl_en         = r_wl;
    assign col_sel       = r_csel;
    assign write_en      = r_wen;
    assign sense_en      = r_sense;
    assign bl_wdata      = r_wdata;
endmodule

// File: tb/tb_sram_col_access_ctrl.sv
// Directed bench for sram_col_access_ctrl: vector table plus
// hand-written back-to-back and mid-access reset sequences.
module tb_sram_col_access_ctrl;
    localparam int PRE = 2;
    localparam int WL  = 3;
`ifdef SRAM_CTRL_BREAK_BEFORE_MAKE_EN
    localparam int BBM = 1;
`else
    localparam int BBM = 0;
`endif
    localparam int SA  = PRE + 1 + BBM;
    localparam int LAT = PRE + WL + 1 + 2 * BBM;
    localparam int NV  = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_col_access_ctrl_if #(.WORD(32), .AW(9)) bus ();

    logic         precharge_en;
    logic [127:0] wl_en;
    logic [3:0]   col_sel;
    logic         write_en;
    logic         sense_en;
    logic [31:0]  bl_wdata;
    logic [31:0]  bl_rdata;

    sram_col_access_ctrl #(
        .ROWS(128), .COLS(128), .WORD(32),
        .PRE_CYC(PRE), .WL_CYC(WL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .precharge_en (precharge_en),
        .wl_en        (wl_en),
        .col_sel      (col_sel),
        .write_en     (write_en),
        .sense_en     (sense_en),
        .bl_wdata     (bl_wdata),
        .bl_rdata     (bl_rdata)
    );

    typedef struct {
        logic        we;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          row;
        int          col;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vt [NV];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    initial begin
        logic [31:0] prev_rd;
        bit prech, setup, hold, acc;
        int acc_cnt, last_acc, gap_bad, ovl, oh_bad, rsp_cnt;

        vt[0] = '{1'b1, 9'h016, 32'hDEADBEEF, 32'h0BAD0BAD, 5,   2, 32'h0};
        vt[1] = '{1'b0, 9'h1FF, 32'h0,        32'h12345678, 127, 3, 32'h12345678};
        vt[2] = '{1'b1, 9'h000, 32'hA5A5A5A5, 32'hFFFFFFFF, 0,   0, 32'h12345678};
        vt[3] = '{1'b0, 9'h003, 32'h0,        32'h00000000, 0,   3, 32'h00000000};
        vt[4] = '{1'b0, 9'h081, 32'h0,        32'hCAFEF00D, 32,  1, 32'hCAFEF00D};

        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bl_rdata      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst ready",  128'(bus.req_ready), 128'(1));
        chk("rst rsp",    128'(bus.rsp_valid), 128'(0));
        chk("rst rdata",  128'(bus.rsp_rdata), 128'(0));
        chk("rst pre",    128'(precharge_en),  128'(0));
        chk("rst wl",     wl_en,               128'(0));
        chk("rst col",    128'(col_sel),       128'(0));
        chk("rst wen",    128'(write_en),      128'(0));
        chk("rst sense",  128'(sense_en),      128'(0));
        chk("rst wdata",  128'(bl_wdata),      128'(0));
        rst = 1'b0;

        prev_rd = 32'h0;
        for (int v = 0; v < NV; v++) begin
            bl_rdata      = vt[v].rdata;
            bus.req_valid = 1'b1;
            bus.req_we    = vt[v].we;
            bus.req_addr  = vt[v].addr;
            bus.req_wdata = vt[v].wdata;
            chk($sformatf("v%0d ready0", v), 128'(bus.req_ready), 128'(1));
            for (int k = 1; k <= LAT + 1; k++) begin
                @(negedge clk);
                if (k == 1) begin
                    bus.req_valid = 1'b0;
                    bus.req_wdata = 32'h0;
                end
                prech = (k >= 1) && (k <= PRE);
                setup = (BBM == 1) && (k == PRE + 1);
                acc   = (k >= SA) && (k < SA + WL);
                hold  = (BBM == 1) && (k == SA + WL);
                chk($sformatf("v%0d c%0d pre", v, k),
                    128'(precharge_en), 128'(prech));
                chk($sformatf("v%0d c%0d wl", v, k), wl_en,
                    acc ? (128'(1) << vt[v].row) : 128'(0));
                chk($sformatf("v%0d c%0d col", v, k), 128'(col_sel),
                    acc ? (128'(1) << vt[v].col) : 128'(0));
                chk($sformatf("v%0d c%0d wen", v, k), 128'(write_en),
                    128'(vt[v].we && (acc || setup || hold)));
                chk($sformatf("v%0d c%0d sense", v, k), 128'(sense_en),
                    128'(!vt[v].we && (k == SA + WL - 1)));
                chk($sformatf("v%0d c%0d rsp", v, k),
                    128'(bus.rsp_valid), 128'(k == LAT));
                chk($sformatf("v%0d c%0d ready", v, k),
                    128'(bus.req_ready), 128'(k == LAT + 1));
                chk($sformatf("v%0d c%0d rdata", v, k), 128'(bus.rsp_rdata),
                    128'((k >= SA + WL) ? vt[v].exp_rd : prev_rd));
                chk($sformatf("v%0d c%0d bl_wdata", v, k),
                    128'(bl_wdata), 128'(vt[v].wdata));
            end
            prev_rd = vt[v].exp_rd;
        end

        // Back-to-back: valid held high, one accept per LAT+1 cycles.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 9'h016;
        bus.req_wdata = 32'h11112222;
        acc_cnt = 0; last_acc = -1; gap_bad = 0; ovl = 0; oh_bad = 0;
        for (int k = 0; k < 4 * (LAT + 1); k++) begin
            if (bus.req_ready) begin
                if (last_acc >= 0 && (k - last_acc) != LAT + 1) gap_bad++;
                last_acc = k;
                acc_cnt++;
            end
            if (precharge_en && (wl_en != 128'(0))) ovl++;
            if (!$onehot0(wl_en) || !$onehot0(col_sel)) oh_bad++;
            if (write_en && (col_sel == 4'b0) && (BBM == 0)) oh_bad++;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        chk("b2b accepts", 128'(acc_cnt), 128'(4));
        chk("b2b spacing", 128'(gap_bad), 128'(0));
        chk("b2b overlap", 128'(ovl),     128'(0));
        chk("b2b onehot",  128'(oh_bad),  128'(0));
        repeat (LAT + 2) @(negedge clk);
        chk("b2b idle", 128'(bus.req_ready), 128'(1));

        // Reset in the middle of a write's ACCESS phase.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 9'h016;
        bus.req_wdata = 32'hDEADBEEF;
        for (int k = 1; k <= SA + 1; k++) begin
            @(negedge clk);
            if (k == 1) bus.req_valid = 1'b0;
        end
        chk("mid wl on",  wl_en, 128'(1) << 5);
        chk("mid rdata",  128'(bus.rsp_rdata), 128'(32'hCAFEF00D));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("ar ready", 128'(bus.req_ready), 128'(1));
        chk("ar pre",   128'(precharge_en),  128'(0));
        chk("ar wl",    wl_en,               128'(0));
        chk("ar col",   128'(col_sel),       128'(0));
        chk("ar wen",   128'(write_en),      128'(0));
        chk("ar sense", 128'(sense_en),      128'(0));
        chk("ar rsp",   128'(bus.rsp_valid), 128'(0));
        chk("ar rdata", 128'(bus.rsp_rdata), 128'(0));
        chk("ar wdata", 128'(bl_wdata),      128'(0));
        rsp_cnt = 0;
        for (int k = 0; k < LAT + 2; k++) begin
            @(negedge clk);
            if (bus.rsp_valid || !bus.req_ready) rsp_cnt++;
        end
        chk("ar no rsp", 128'(rsp_cnt), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
